// File: rtl/icn_arb.sv
// Round-robin arbiter: NREQ 4-phase requesters share one ICN input port through a one-entry token buffer.
// Define ICN_ARB_SYNC_EN to pass req_i/ack_i through 2-flop synchronizers first. Each sampled-input timing then moves 2 cycles later.
module icn_arb #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_i,
  input  logic [67*NREQ-1:0]   tok_i,
  output logic [NREQ-1:0]      ack_o,
  output logic                 send_o,
  input  logic                 ack_i,
  output logic [2:0]           pe_num_o,
  output logic [1:0]           mem_w_o,
  output logic                 lr_o,
  output logic [15:0]          node_o,
  output logic [11:0]          gen_o,
  output logic [31:0]          opr_o,
  output logic                 uni_opr_o,
  output logic [2:0]           grant_id_o,
  output logic                 busy_o
);

  typedef struct packed {
    logic        uni_opr;
    logic [31:0] opr;
    logic [11:0] gen;
    logic [15:0] node;
    logic        lr;
    logic [1:0]  mem_w;
    logic [2:0]  pe_num;
  } tok_t;

  typedef enum logic       {IN_IDLE, IN_WAIT_LO} in_st_t;
  typedef enum logic [1:0] {OUT_IDLE, OUT_WAIT_HI, OUT_WAIT_LO} out_st_t;

  tok_t [NREQ-1:0] tok_arr;
  assign tok_arr = tok_i;

  logic [NREQ-1:0] req_s;
  logic            ack_s;

`ifdef ICN_ARB_SYNC_EN
  logic [1:0][NREQ-1:0] req_sync_q;
  logic [1:0]           ack_sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_sync_q <= '0;
      ack_sync_q <= '0;
    end else begin
      req_sync_q <= {req_sync_q[0], req_i};
      ack_sync_q <= {ack_sync_q[0], ack_i};
    end
  end
  assign req_s = req_sync_q[1];
  assign ack_s = ack_sync_q[1];
`else
  assign req_s = req_i;
  assign ack_s = ack_i;
`endif

  in_st_t          in_q;
  out_st_t         out_q;
  logic [2:0]      ptr_q, gid_q;
  logic [NREQ-1:0] ack_q;
  tok_t            tok_q;
  logic            full_q, send_q;

  // Round-robin search from ptr_q; constant inner index keeps every select in range for any NREQ.
  logic [3:0]      idx;
  logic            found;
  logic [2:0]      win;
  logic [NREQ-1:0] win_oh;
  tok_t            tok_win;

  always_comb begin
    idx     = '0;
    found   = 1'b0;
    win     = '0;
    win_oh  = '0;
    tok_win = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr_q} + 4'(i);
      if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
      for (int j = 0; j < NREQ; j++) begin
        if (!found && idx == 4'(j) && req_s[j]) begin
          found     = 1'b1;
          win       = 3'(j);
          win_oh[j] = 1'b1;
          tok_win   = tok_arr[j];
        end
      end
    end
  end

  // Grant needs an empty buffer and free needs a full one, so they can never share an edge.
  logic grant, free;
  assign grant = (in_q == IN_IDLE) && !full_q && found;
  assign free  = (out_q == OUT_WAIT_LO) && !ack_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_q  <= IN_IDLE;
      ack_q <= '0;
      ptr_q <= '0;
      gid_q <= '0;
      tok_q <= '0;
    end else begin
      case (in_q)
        IN_IDLE: if (grant) begin
          ack_q <= win_oh;
          gid_q <= win;
          tok_q <= tok_win;
          ptr_q <= (win == 3'(NREQ-1)) ? 3'd0 : win + 3'd1;
          in_q  <= IN_WAIT_LO;
        end
        IN_WAIT_LO: if ((req_s & ack_q) == '0) begin
          ack_q <= '0;
          in_q  <= IN_IDLE;
        end
        default: in_q <= IN_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       full_q <= 1'b0;
    else if (grant) full_q <= 1'b1;
    else if (free)  full_q <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q  <= OUT_IDLE;
      send_q <= 1'b0;
    end else begin
      case (out_q)
        OUT_IDLE: if (full_q) begin
          send_q <= 1'b1;
          out_q  <= OUT_WAIT_HI;
        end
        OUT_WAIT_HI: if (ack_s) begin
          send_q <= 1'b0;
          out_q  <= OUT_WAIT_LO;
        end
        OUT_WAIT_LO: if (!ack_s) out_q <= OUT_IDLE;
        default: out_q <= OUT_IDLE;
      endcase
    end
  end

  assign ack_o      = ack_q;
  assign send_o     = send_q;
  assign busy_o     = full_q;
  assign grant_id_o = gid_q;
  assign pe_num_o   = tok_q.pe_num;
  assign mem_w_o    = tok_q.mem_w;
  assign lr_o       = tok_q.lr;
  assign node_o     = tok_q.node;
  assign gen_o      = tok_q.gen;
  assign opr_o      = tok_q.opr;
  assign uni_opr_o  = tok_q.uni_opr;

endmodule

// File: tb/tb_icn_arb.sv
// Directed bench for icn_arb: single grant, wrap, round-robin order, ICN stall, mid-handshake reset.
// Build with ICN_ARB_SYNC_EN defined to check the synchronized input timing.
module tb_icn_arb;
  localparam int NREQ = 4;
`ifdef ICN_ARB_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_i = '0;
  logic [67*NREQ-1:0] tok_i = '0;
  logic [NREQ-1:0]   ack_o;
  logic              send_o, ack_i, lr_o, uni_opr_o, busy_o;
  logic [2:0]        pe_num_o, grant_id_o;
  logic [1:0]        mem_w_o;
  logic [15:0]       node_o;
  logic [11:0]       gen_o;
  logic [31:0]       opr_o;
  logic              icn_auto = 1'b0;
  logic              icn_val  = 1'b0;
  logic [66:0]       tk [NREQ];
  logic [66:0]       out_tok;

  icn_arb #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .tok_i(tok_i), .ack_o(ack_o),
    .send_o(send_o), .ack_i(ack_i), .pe_num_o(pe_num_o), .mem_w_o(mem_w_o),
    .lr_o(lr_o), .node_o(node_o), .gen_o(gen_o), .opr_o(opr_o),
    .uni_opr_o(uni_opr_o), .grant_id_o(grant_id_o), .busy_o(busy_o)
  );

  assign out_tok = {uni_opr_o, opr_o, gen_o, node_o, lr_o, mem_w_o, pe_num_o};

  always #5 clk = ~clk;

  // ICN side: either a prompt 4-phase responder or a fixed level.
  initial begin
    ack_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      ack_i = icn_auto ? send_o : icn_val;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [66:0] act, input logic [66:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drop all requests, let the ICN finish, and require 4 quiet cycles in a row.
  task automatic drain(input string tag);
    int quiet;
    quiet = 0;
    req_i = '0;
    icn_auto = 1'b1;
    for (int i = 0; i < 80 && quiet < 4; i++) begin
      tick();
      if (!busy_o && ack_o == '0 && !send_o) quiet++;
      else quiet = 0;
    end
    chk(tag, 67'(quiet >= 4), 67'd1);
  endtask

  task automatic wait_ack(input string tag, input logic [NREQ-1:0] mask);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      tick();
      if ((ack_o & mask) != '0) hit = 1'b1;
    end
    chk(tag, 67'(hit), 67'd1);
  endtask

  task automatic pulse_rst();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  logic [2:0] got [5];
  logic [2:0] exp_ord [5];
  int         cnt;
  logic [NREQ-1:0] prev;
  logic            hit;

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      tk[k] = {k[0], 32'hC0DE0000 | 32'(k), 12'(12'h100 + k),
               (k == 2) ? 16'h1234 : 16'(16'hA000 + k), ~k[0], 2'(k), 3'(k + 4)};
      tok_i[67*k +: 67] = tk[k];
    end
    exp_ord[0] = 3'd0; exp_ord[1] = 3'd1; exp_ord[2] = 3'd2; exp_ord[3] = 3'd3; exp_ord[4] = 3'd0;

    repeat (2) tick();
    chk("rst_ack",  67'(ack_o), 67'd0);
    chk("rst_send", 67'(send_o), 67'd0);
    chk("rst_busy", 67'(busy_o), 67'd0);
    chk("rst_gid",  67'(grant_id_o), 67'd0);
    chk("rst_tok",  out_tok, 67'd0);
    rst = 1'b1;
    tick();

    // Single request from requester 2.
    req_i = 4'b0100;
    for (int i = 0; i < LAT; i++) begin
      tick();
      chk("s1_ack_early", 67'(ack_o), 67'd0);
    end
    tick();
    chk("s1_ack",  67'(ack_o), 67'b0100);
    chk("s1_gid",  67'(grant_id_o), 67'd2);
    chk("s1_busy", 67'(busy_o), 67'd1);
    chk("s1_send_lat", 67'(send_o), 67'd0);
    tick();
    chk("s1_send", 67'(send_o), 67'd1);
    chk("s1_node", 67'(node_o), 67'h1234);
    chk("s1_tok",  out_tok, tk[2]);
    drain("s1_drain");

    // Pointer now 3: requesters 3 and 0 -> 3 first, then wrap to 0.
    req_i = 4'b1001;
    repeat (LAT) tick();
    tick();
    chk("wrap_gid3", 67'(grant_id_o), 67'd3);
    chk("wrap_ack3", 67'(ack_o), 67'b1000);
    req_i = 4'b0001;
    wait_ack("wrap_wait0", 4'b0001);
    chk("wrap_gid0", 67'(grant_id_o), 67'd0);
    chk("wrap_ack0", 67'(ack_o), 67'b0001);
    chk("wrap_tok0", out_tok, tk[0]);
    drain("wrap_drain");

    // All requesters, 4-phase each, prompt ICN -> 0,1,2,3,0.
    pulse_rst();
    icn_auto = 1'b1;
    req_i = 4'b1111;
    cnt = 0;
    prev = '0;
    for (int i = 0; i < 100 && cnt < 5; i++) begin
      tick();
      if ((ack_o & ~prev) != '0) begin
        got[cnt] = grant_id_o;
        cnt++;
      end
      prev = ack_o;
      req_i = ~ack_o;
    end
    chk("ord_cnt", 67'(cnt), 67'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("ord_%0d", i), 67'(got[i]), 67'(exp_ord[i]));
    drain("ord_drain");

    // ICN stall: pointer is 1, so requester 1 wins; others keep requesting.
    icn_auto = 1'b0;
    icn_val = 1'b0;
    req_i = 4'b1111;
    wait_ack("st_wait", 4'b1111);
    chk("st_gid", 67'(grant_id_o), 67'd1);
    req_i = 4'b1101;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (send_o) hit = 1'b1;
      else tick();
    end
    chk("st_send_up", 67'(hit), 67'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("st_send",  67'(send_o), 67'd1);
      chk("st_busy",  67'(busy_o), 67'd1);
      chk("st_noack", 67'(ack_o & 4'b1101), 67'd0);
      chk("st_gid_hold", 67'(grant_id_o), 67'd1);
      chk("st_tok", out_tok, tk[1]);
    end

    // Reset while waiting for ICN ack high.
    rst = 1'b0;
    #1;
    chk("mr_ack",  67'(ack_o), 67'd0);
    chk("mr_send", 67'(send_o), 67'd0);
    chk("mr_busy", 67'(busy_o), 67'd0);
    chk("mr_gid",  67'(grant_id_o), 67'd0);
    chk("mr_tok",  out_tok, 67'd0);
    req_i = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    req_i = 4'b0010;
    repeat (LAT) tick();
    tick();
    chk("mr_gid1", 67'(grant_id_o), 67'd1);
    chk("mr_ack1", 67'(ack_o), 67'b0010);
    drain("mr_drain");

    // Pointer is 2 here; a reset must return it to 0, so 4'b1001 grants 0.
    pulse_rst();
    req_i = 4'b1001;
    repeat (LAT) tick();
    tick();
    chk("pr_gid0", 67'(grant_id_o), 67'd0);
    chk("pr_ack0", 67'(ack_o), 67'b0001);
    drain("pr_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
